demux_stream_1ton: RTL and testbench
====================================

Name: demux_stream_1ton

Overview:
- Parametrised, registered 1-to-N demultiplexer; successor to the combinational 1-to-2 demux.
- Routes a valid/ready input stream to one of N output channels by select, or to all channels in broadcast mode.
- Each channel has a one-entry output register with its own valid/ready handshake.
- Out-of-range selects are consumed, dropped and flagged.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- W, 8, data width in bits
- N, 4, number of output channels (N >= 2; need not be a power of 2)
- SW, $clog2(N), select width; derived localparam, not overridable

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_data  input  W  input payload
- in_sel  input  SW  destination channel index
- in_bcast  input  1  1 = deliver to all N channels; in_sel ignored
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted this cycle when in_valid & in_ready
- out_data  output  N*W  channel k payload in bits [k*W +: W]
- out_valid  output  N  channel k holds a beat
- out_ready  input  N  consumer k accepts the beat
- err_sel  output  1  sticky: an out-of-range select was received
- drop_cnt  output  8  saturating count of dropped beats

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, err_sel=0, drop_cnt=0. A reset mid-transfer discards all held beats; in_ready is combinational and takes its post-reset value once the registers clear.
- can_acc[k] = !out_valid[k] | out_ready[k]. Pipeline-register semantics give full throughput of 1 beat/cycle per channel.
- in_ready, combinational:
  - if in_bcast: AND of can_acc[0..N-1]
  - else if in_sel < N: can_acc[in_sel]
  - else: 1 (drop path never stalls)
- Transfer event: xfer = in_valid & in_ready.
- Channel k load, on xfer when in_bcast, or when !in_bcast & in_sel==k: out_data[k] <= in_data, out_valid[k] <= 1.
- Channel k otherwise: if out_ready[k] & out_valid[k], then out_valid[k] <= 0. out_data[k] holds its value and is not cleared.
- A load and a drain on the same channel in the same cycle is a load: out_valid stays 1 and new data is taken.
- Latency: 1 cycle from an accepted input to out_valid.
- Stability: while out_valid[k] & !out_ready[k], out_data[k] and out_valid[k] hold stable.
- Broadcast is all-or-nothing. No partial delivery; the beat stalls until every channel can accept.
- Out-of-range (xfer & !in_bcast & in_sel >= N):
  - beat is discarded
  - err_sel <= 1, sticky until reset
  - drop_cnt increments, saturating at 255
  - no channel changes state
- Producer rule: in_data, in_sel and in_bcast must be stable while in_valid & !in_ready. The block does not check this.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to in_ready.
- Simultaneous drains on multiple channels are independent.

Decomposition:
- Package demux_pkg:
  - DEMUX_DEF_W = 8
  - DEMUX_DEF_N = 4
  - DROP_CNT_W = 8
  - function sat_inc(count) for the saturating increment
- Sub-module demux_out_slot (parameter W): one channel register.
  - Ports: clk, rst_n, load, d, out_ready, out_data, out_valid, can_acc.
  - The top instantiates N copies in a generate loop.
  - The top holds the select decode, broadcast AND, error flag and drop counter.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0000, err_sel=0, drop_cnt=0; in_ready=1 after release.
- Routing: send 0xA5 sel=2, all out_ready=1 -> next cycle out_valid=0100, out_data[2]=0xA5. Send back-to-back beats to sel 0,1,2,3 -> one beat per cycle, no stall.
- Backpressure: out_ready[1]=0, send 0x11 then 0x22 to sel=1 -> second beat sees in_ready=0; out_data[1] holds 0x11. Raise out_ready[1] -> 0x22 loads in the same cycle 0x11 drains.
- Broadcast: hold out_ready[3]=0 with channel 3 full, send 0x3C with in_bcast=1 -> in_ready=0 and no channel loads. Release out_ready[3] -> all four channels load 0x3C together.
- Out-of-range: N=3, send sel=3 -> in_ready=1, no out_valid change, err_sel=1, drop_cnt=1. Send 300 bad beats -> drop_cnt saturates at 255.
- Mid-operation reset: channels 0 and 2 full and stalled, pulse rst_n=0 for 1 cycle -> out_valid=0000 and out_data=0 on the next edge.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

    localparam int DEMUX_DEF_W = 8;
    localparam int DEMUX_DEF_N = 4;
    localparam int DROP_CNT_W  = 8;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] count);
        logic [DROP_CNT_W-1:0] result;
        if (count == {DROP_CNT_W{1'b1}}) begin
            result = count;
        end else begin
            result = count + DROP_CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a single-entry pipeline register with its own valid/ready handshake.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int W = DEMUX_DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         can_acc
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;
    logic         valid_d;
    logic         valid_q;

    // Next state: a load wins over a same-cycle drain; data is held, never cleared, on drain.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (out_ready && valid_q) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Channel register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign can_acc   = !valid_q || out_ready;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with broadcast, out-of-range drop flagging and drop counting.
module demux_stream_1ton
    import demux_pkg::*;
#(
    parameter int   W  = DEMUX_DEF_W,
    parameter int   N  = DEMUX_DEF_N,
    localparam int  SW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          in_data,
    input  logic [SW-1:0]         in_sel,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N*W-1:0]        out_data,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic                  err_sel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [31:0]           sel_ext_s;
    logic [N-1:0]          sel_hit_s;
    logic [N-1:0]          can_acc_s;
    logic [N-1:0]          load_s;
    logic                  in_ready_s;
    logic                  xfer_s;
    logic                  drop_s;
    logic                  err_d;
    logic                  err_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    assign sel_ext_s = 32'(in_sel);

    // One-hot select decode; an all-zero result means the select is out of range.
    always_comb begin
        sel_hit_s = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_ext_s == 32'(k)) begin
                sel_hit_s[k] = 1'b1;
            end else begin
                sel_hit_s[k] = 1'b0;
            end
        end
    end

    // Acceptance: broadcast needs every channel free; the drop path never stalls.
    always_comb begin
        in_ready_s = 1'b1;
        if (in_bcast) begin
            in_ready_s = &can_acc_s;
        end else if (|sel_hit_s) begin
            in_ready_s = |(sel_hit_s & can_acc_s);
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign in_ready = in_ready_s;
    assign xfer_s   = in_valid && in_ready_s;
    assign drop_s   = xfer_s && !in_bcast && !(|sel_hit_s);

    // Per-channel load strobes.
    always_comb begin
        load_s = '0;
        for (int k = 0; k < N; k++) begin
            load_s[k] = xfer_s && (in_bcast || sel_hit_s[k]);
        end
    end

    // Sticky error flag and saturating drop counter next state.
    always_comb begin
        err_d      = err_q;
        drop_cnt_d = drop_cnt_q;
        if (drop_s) begin
            err_d      = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end else begin
            err_d      = err_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Error/drop status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_sel  = err_q;
    assign drop_cnt = drop_cnt_q;

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_out_slot #(
            .W (W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_s[g]),
            .d         (in_data),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g*W +: W]),
            .out_valid (out_valid[g]),
            .can_acc   (can_acc_s[g])
        );
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed plus randomized bench for demux_stream_1ton: a 4-channel and a 3-channel instance share stimulus.
module tb_demux_stream_1ton;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic        in_valid;
    logic [3:0]  out_ready;

    logic        in_ready4;
    logic [31:0] out_data4;
    logic [3:0]  out_valid4;
    logic        err_sel4;
    logic [7:0]  drop_cnt4;

    logic        in_ready3;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3;
    logic        err_sel3;
    logic [7:0]  drop_cnt3;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 is the 4-channel instance, index 1 the 3-channel one.
    int       nch [2] = '{4, 3};
    bit       m_valid [2][4];
    bit [7:0] m_data [2][4];
    bit       m_err [2];
    int       m_drop [2];

    always #5 clk = ~clk;

    demux_stream_1ton #(.W(8), .N(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .err_sel   (err_sel4),
        .drop_cnt  (drop_cnt4)
    );

    demux_stream_1ton #(.W(8), .N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready[2:0]),
        .err_sel   (err_sel3),
        .drop_cnt  (drop_cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A channel can take a beat if it is empty or being drained this cycle.
    function automatic bit free_ch(input int m, input int k);
        return !m_valid[m][k] || out_ready[k];
    endfunction

    function automatic bit model_ready(input int m);
        bit r;
        r = 1'b1;
        if (in_bcast) begin
            for (int k = 0; k < nch[m]; k++) r = r && free_ch(m, k);
        end else if (int'(in_sel) < nch[m]) begin
            r = free_ch(m, int'(in_sel));
        end
        return r;
    endfunction

    task automatic model_update(input int m, input bit rdy);
        bit xfer;
        xfer = in_valid && rdy;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_valid[m][k] = 1'b0;
                m_data[m][k]  = 8'h00;
            end
            m_err[m]  = 1'b0;
            m_drop[m] = 0;
        end else begin
            for (int k = 0; k < nch[m]; k++) begin
                if (xfer && (in_bcast || int'(in_sel) == k)) begin
                    m_valid[m][k] = 1'b1;
                    m_data[m][k]  = in_data;
                end else if (out_ready[k]) begin
                    m_valid[m][k] = 1'b0;
                end
            end
            if (xfer && !in_bcast && int'(in_sel) >= nch[m]) begin
                m_err[m]  = 1'b1;
                m_drop[m] = (m_drop[m] < 255) ? m_drop[m] + 1 : 255;
            end
        end
    endtask

    // One clock: check in_ready on the current inputs, advance model at the edge, then check registers.
    task automatic step(input bit chk_rdy);
        bit er [2];
        logic [31:0] ed4;
        logic [23:0] ed3;
        logic [3:0]  ev4;
        logic [2:0]  ev3;
        #1;
        er[0] = model_ready(0);
        er[1] = model_ready(1);
        if (chk_rdy) begin
            chk("in_ready_n4", 64'(in_ready4), 64'(er[0]));
            chk("in_ready_n3", 64'(in_ready3), 64'(er[1]));
        end
        @(posedge clk);
        model_update(0, er[0]);
        model_update(1, er[1]);
        #1;
        for (int k = 0; k < 4; k++) begin
            ev4[k]        = m_valid[0][k];
            ed4[k*8 +: 8] = m_data[0][k];
        end
        for (int k = 0; k < 3; k++) begin
            ev3[k]        = m_valid[1][k];
            ed3[k*8 +: 8] = m_data[1][k];
        end
        chk("out_valid_n4", 64'(out_valid4), 64'(ev4));
        chk("out_data_n4",  64'(out_data4),  64'(ed4));
        chk("err_sel_n4",   64'(err_sel4),   64'(m_err[0]));
        chk("drop_cnt_n4",  64'(drop_cnt4),  64'(m_drop[0]));
        chk("out_valid_n3", 64'(out_valid3), 64'(ev3));
        chk("out_data_n3",  64'(out_data3),  64'(ed3));
        chk("err_sel_n3",   64'(err_sel3),   64'(m_err[1]));
        chk("drop_cnt_n3",  64'(drop_cnt3),  64'(m_drop[1]));
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic b);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_bcast = b;
        step(1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_sel    = 2'd1;
        in_bcast  = 1'b0;
        out_ready = 4'b1111;
        @(negedge clk);

        // Reset held two cycles with a valid beat presented.
        step(1'b0);
        step(1'b1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rdy_after_reset", 64'(in_ready4), 64'(1'b1));
        step(1'b1);

        // Routing and back-to-back throughput.
        send(8'hA5, 2'd2, 1'b0);
        chk("route_valid", 64'(out_valid4), 64'(4'b0100));
        chk("route_data",  64'(out_data4[23:16]), 64'(8'hA5));
        for (int s = 0; s < 4; s++) send(8'($urandom), 2'(s), 1'b0);

        // Backpressure on channel 1.
        out_ready = 4'b1101;
        send(8'h11, 2'd1, 1'b0);
        in_data = 8'h22;
        #1;
        chk("bp_stall", 64'(in_ready4), 64'(1'b0));
        send(8'h22, 2'd1, 1'b0);
        chk("bp_hold", 64'(out_data4[15:8]), 64'(8'h11));
        out_ready = 4'b1111;
        send(8'h22, 2'd1, 1'b0);
        chk("bp_load", 64'(out_data4[15:8]), 64'(8'h22));

        // All-or-nothing broadcast.
        out_ready = 4'b0111;
        send(8'h77, 2'd3, 1'b0);
        send(8'h3C, 2'd0, 1'b1);
        chk("bc_stall_valid", 64'(out_valid4), 64'(4'b1000));
        out_ready = 4'b1111;
        send(8'h3C, 2'd0, 1'b1);
        chk("bc_all_valid", 64'(out_valid4), 64'(4'b1111));
        chk("bc_all_data",  64'(out_data4),  64'(32'h3C3C3C3C));

        // Out-of-range on the 3-channel instance, up to saturation.
        out_ready = 4'b0000;
        send(8'hEE, 2'd3, 1'b0);
        chk("oor_err", 64'(err_sel3), 64'(1'b1));
        for (int i = 0; i < 300; i++) begin
            out_ready = 4'(i % 2 == 0 ? 4'b1111 : 4'b0000);
            send(8'($urandom), 2'd3, 1'b0);
        end
        chk("oor_sat", 64'(drop_cnt3), 64'(8'd255));

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_sel    = 2'($urandom);
            in_bcast  = ($urandom_range(0, 7) == 0);
            out_ready = 4'($urandom);
            step(1'b1);
        end

        // Reset while channels 0 and 2 are full and stalled.
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        step(1'b1);
        out_ready = 4'b0000;
        send(8'h81, 2'd0, 1'b0);
        send(8'h82, 2'd2, 1'b0);
        chk("pre_rst_valid", 64'(out_valid4), 64'(4'b0101));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step(1'b1);
        chk("mid_rst_valid", 64'(out_valid4), 64'(4'b0000));
        chk("mid_rst_data",  64'(out_data4),  64'(32'h0));
        rst_n = 1'b1;
        step(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
